// File: rtl/gnr_pkg.sv
// rtl/gnr_pkg.sv - shared types and defaults for the gene regulatory network attractor controller
package gnr_pkg;

    localparam int GNR_NUM_NOS = 8;
    localparam int GNR_CNT_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MEET,
        ST_PERIOD,
        ST_REPORT,
        ST_NEXT,
        ST_DONE
    } gnr_state_e;

    typedef struct packed {
        logic [GNR_NUM_NOS-1:0] init;
        logic [GNR_CNT_W-1:0]   meet;
        logic [GNR_CNT_W-1:0]   period;
        logic                   timeout;
    } gnr_result_t;

endpackage

// File: rtl/gnr_step_counter.sv
// rtl/gnr_step_counter.sv - clearable step counter that sticks at all-ones, with a limit compare
module gnr_step_counter
    import gnr_pkg::*;
#(
    parameter int CNT_W = GNR_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             sat,
    output logic             at_limit
);

    assign sat      = &count;
    assign at_limit = (count == limit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !sat) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/gnr_attractor_ctrl.sv
// rtl/gnr_attractor_ctrl.sv - sequences initial states through the network and reports each attractor
// found by a tortoise/hare meet search followed by a period count.
module gnr_attractor_ctrl
    import gnr_pkg::*;
#(
    parameter int NUM_NOS   = GNR_NUM_NOS,
    parameter int CNT_W     = GNR_CNT_W,
    parameter int MAX_STEPS = 65535
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [NUM_NOS-1:0] init_base,
    input  logic [NUM_NOS:0]   init_count,
    input  logic [NUM_NOS-1:0] s0_vec,
    input  logic [NUM_NOS-1:0] s1_vec,
    output logic               reset_nos,
    output logic               start_s0,
    output logic               start_s1,
    output logic [NUM_NOS-1:0] init_state,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [NUM_NOS-1:0] res_init,
    output logic [CNT_W-1:0]   res_meet,
    output logic [CNT_W-1:0]   res_period,
    output logic               res_timeout,
    output logic               busy,
    output logic               done
);

    localparam logic [CNT_W-1:0] STEP_LIMIT = CNT_W'(MAX_STEPS);
    localparam logic [CNT_W-1:0] PER_LIMIT  = '1;

    gnr_state_e         state;
    logic [NUM_NOS-1:0] cur;
    logic [NUM_NOS:0]   remaining;
    logic [CNT_W-1:0]   step_cnt;
    logic [CNT_W-1:0]   per_cnt;
    logic               step_sat, step_at_lim;
    logic               per_sat, per_at_lim;
    logic               vec_eq, meet_hit, meet_to, per_hit, per_to, per_step;
    logic               unused_flags;

    // Strobes are decoded from the live compare so the step that would overshoot a match is never issued.
    assign vec_eq   = (s0_vec == s1_vec);
    assign meet_hit = (state == ST_MEET) && (step_cnt >= CNT_W'(2)) && vec_eq;
    assign meet_to  = (state == ST_MEET) && !meet_hit && step_at_lim;
    assign per_hit  = (state == ST_PERIOD) && (per_cnt != '0) && vec_eq;
    assign per_to   = (state == ST_PERIOD) && !per_hit && per_sat;
    assign per_step = (state == ST_PERIOD) && !per_hit && !per_to;

    assign start_s0   = (state == ST_MEET) && !meet_hit && !meet_to;
    assign start_s1   = start_s0 || per_step;
    assign reset_nos  = (state == ST_LOAD);
    assign busy       = (state != ST_IDLE);
    assign init_state = cur;

    assign unused_flags = step_sat ^ per_at_lim;

    gnr_step_counter #(.CNT_W(CNT_W)) u_step_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (state == ST_LOAD),
        .en       (start_s0),
        .limit    (STEP_LIMIT),
        .count    (step_cnt),
        .sat      (step_sat),
        .at_limit (step_at_lim)
    );

    gnr_step_counter #(.CNT_W(CNT_W)) u_per_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (state == ST_LOAD),
        .en       (per_step),
        .limit    (PER_LIMIT),
        .count    (per_cnt),
        .sat      (per_sat),
        .at_limit (per_at_lim)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cur         <= '0;
            remaining   <= '0;
            res_valid   <= 1'b0;
            res_init    <= '0;
            res_meet    <= '0;
            res_period  <= '0;
            res_timeout <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        cur       <= init_base;
                        remaining <= init_count;
                        state     <= (init_count == '0) ? ST_DONE : ST_LOAD;
                    end
                end
                ST_LOAD: state <= ST_MEET;
                ST_MEET: begin
                    if (meet_hit) begin
                        res_meet <= step_cnt;
                        state    <= ST_PERIOD;
                    end else if (meet_to) begin
                        res_meet    <= step_cnt;
                        res_period  <= '0;
                        res_timeout <= 1'b1;
                        res_init    <= cur;
                        res_valid   <= 1'b1;
                        state       <= ST_REPORT;
                    end
                end
                ST_PERIOD: begin
                    if (per_hit || per_to) begin
                        res_period  <= per_hit ? per_cnt : '0;
                        res_timeout <= per_to;
                        res_init    <= cur;
                        res_valid   <= 1'b1;
                        state       <= ST_REPORT;
                    end
                end
                ST_REPORT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        remaining <= remaining - 1'b1;
                        cur       <= cur + 1'b1;
                        state     <= ST_NEXT;
                    end
                end
                ST_NEXT: state <= (remaining != '0) ? ST_LOAD : ST_DONE;
                ST_DONE: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// tb/tb_gnr_attractor_ctrl.sv - scoreboard bench driving two controllers (long and short step limit)
// against a behavioural 4-node tortoise/hare network.
module tb_gnr_attractor_ctrl;

    localparam int NN   = 4;
    localparam int CW   = 16;
    localparam int MAX0 = 65535;
    localparam int MAX1 = 8;

    typedef struct {
        logic [NN-1:0] init;
        int            meet;
        int            period;
        bit            to;
        int            ns0;
        int            ns1;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic [NN-1:0] init_base;
    logic [NN:0]   init_count;
    logic [1:0]    res_ready;

    logic [1:0][NN-1:0] s0_m, s1_m, init_state_w, res_init_w;
    logic [1:0][CW-1:0] res_meet_w, res_period_w;
    logic [1:0]         par, reset_nos_w, ss0_w, ss1_w, res_valid_w, res_timeout_w, busy_w, done_w;

    logic [NN-1:0] fn [16];
    exp_t          sbq [2][$];
    int            s0c [2];
    int            s1c [2];
    int            done_cnt [2];
    bit            hold_v [2];
    logic [36:0]   held [2];
    int            n_pass, n_tot;

    gnr_attractor_ctrl #(.NUM_NOS(NN), .CNT_W(CW), .MAX_STEPS(MAX0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .init_base(init_base), .init_count(init_count),
        .s0_vec(s0_m[0]), .s1_vec(s1_m[0]), .reset_nos(reset_nos_w[0]), .start_s0(ss0_w[0]),
        .start_s1(ss1_w[0]), .init_state(init_state_w[0]), .res_valid(res_valid_w[0]),
        .res_ready(res_ready[0]), .res_init(res_init_w[0]), .res_meet(res_meet_w[0]),
        .res_period(res_period_w[0]), .res_timeout(res_timeout_w[0]), .busy(busy_w[0]), .done(done_w[0])
    );

    gnr_attractor_ctrl #(.NUM_NOS(NN), .CNT_W(CW), .MAX_STEPS(MAX1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .init_base(init_base), .init_count(init_count),
        .s0_vec(s0_m[1]), .s1_vec(s1_m[1]), .reset_nos(reset_nos_w[1]), .start_s0(ss0_w[1]),
        .start_s1(ss1_w[1]), .init_state(init_state_w[1]), .res_valid(res_valid_w[1]),
        .res_ready(res_ready[1]), .res_init(res_init_w[1]), .res_meet(res_meet_w[1]),
        .res_period(res_period_w[1]), .res_timeout(res_timeout_w[1]), .busy(busy_w[1]), .done(done_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        s0_m = '0;
        s1_m = '0;
        par  = '0;
    end

    // Network: hare steps on every start_s1, tortoise on every second start_s0.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset_nos_w[d]) begin
                s0_m[d] <= init_state_w[d];
                s1_m[d] <= init_state_w[d];
                par[d]  <= 1'b0;
            end else begin
                if (ss1_w[d]) s1_m[d] <= fn[s1_m[d]];
                if (ss0_w[d]) begin
                    par[d] <= ~par[d];
                    if (!par[d]) s0_m[d] <= fn[s0_m[d]];
                end
            end
        end
    end

    task automatic chk(input string nm, input int d, input longint act, input longint exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s [dut%0d]: got %0d, expected %0d", nm, d, act, exp);
    endtask

    function automatic logic [46:0] outs(input int d);
        return {reset_nos_w[d], ss0_w[d], ss1_w[d], init_state_w[d], res_valid_w[d], res_init_w[d],
                res_meet_w[d], res_period_w[d], res_timeout_w[d], busy_w[d], done_w[d]};
    endfunction

    function automatic logic [NN-1:0] walk(input logic [NN-1:0] x0, input int n);
        logic [NN-1:0] x;
        x = x0;
        for (int i = 0; i < n; i++) x = fn[x];
        return x;
    endfunction

    // Reference: first k>=2 with x_k == x_ceil(k/2), then cycle length seen from the frozen tortoise.
    function automatic exp_t ref_rec(input logic [NN-1:0] x0, input int maxs);
        exp_t e;
        e.init = x0; e.meet = maxs; e.period = 0; e.to = 1'b1;
        for (int k = 2; k <= maxs; k++) begin
            if (walk(x0, k) == walk(x0, (k + 1) / 2)) begin
                e.meet = k;
                e.to   = 1'b0;
                for (int p = 1; p <= 16; p++) begin
                    if (walk(x0, k + p) == walk(x0, (k + 1) / 2)) begin
                        e.period = p;
                        break;
                    end
                end
                break;
            end
        end
        e.ns0 = e.meet;
        e.ns1 = e.meet + e.period;
        return e;
    endfunction

    // Monitor: strobe accounting, load checks, report-phase quietness and record scoreboard.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                hold_v[d] = 1'b0;
            end else begin
                if (reset_nos_w[d]) begin
                    s0c[d] = 0;
                    s1c[d] = 0;
                    if (sbq[d].size() == 0) chk("unexpected_load", d, 1, 0);
                    else chk("load_init_state", d, init_state_w[d], sbq[d][0].init);
                end
                if (ss0_w[d]) s0c[d]++;
                if (ss1_w[d]) s1c[d]++;
                if (res_valid_w[d]) begin
                    chk("quiet_in_report", d, {reset_nos_w[d], ss0_w[d], ss1_w[d]}, 0);
                    if (hold_v[d])
                        chk("stable_while_stalled", d,
                            {res_init_w[d], res_meet_w[d], res_period_w[d], res_timeout_w[d]}, held[d]);
                    if (res_ready[d]) begin
                        hold_v[d] = 1'b0;
                        if (sbq[d].size() == 0) begin
                            chk("unexpected_record", d, 1, 0);
                        end else begin
                            e = sbq[d].pop_front();
                            chk("rec_init", d, res_init_w[d], e.init);
                            chk("rec_meet", d, res_meet_w[d], e.meet);
                            chk("rec_period", d, res_period_w[d], e.period);
                            chk("rec_timeout", d, res_timeout_w[d], e.to);
                            chk("rec_s0_strobes", d, s0c[d], e.ns0);
                            chk("rec_s1_strobes", d, s1c[d], e.ns1);
                        end
                    end else begin
                        hold_v[d] = 1'b1;
                        held[d]   = {res_init_w[d], res_meet_w[d], res_period_w[d], res_timeout_w[d]};
                    end
                end else begin
                    hold_v[d] = 1'b0;
                end
                if (done_w[d]) done_cnt[d]++;
            end
        end
    end

    task automatic push_expected(input logic [NN-1:0] base, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            sbq[0].push_back(ref_rec(NN'(base + i), MAX0));
            sbq[1].push_back(ref_rec(NN'(base + i), MAX1));
        end
    endtask

    task automatic wait_done(input int b0, input int b1);
        int g;
        g = 0;
        while ((done_cnt[0] <= b0 || done_cnt[1] <= b1) && g < 6000) begin
            @(posedge clk); #2;
            g++;
        end
        chk("run_finished", 0, longint'(done_cnt[0] > b0 && done_cnt[1] > b1), 1);
        for (int d = 0; d < 2; d++) chk("all_records_seen", d, sbq[d].size(), 0);
    endtask

    task automatic do_run(input logic [NN-1:0] base, input int cnt, input int stall, input bit bpulse);
        int b0, b1, g;
        b0 = done_cnt[0];
        b1 = done_cnt[1];
        push_expected(base, cnt);
        res_ready = (stall > 0) ? 2'b10 : 2'b11;
        @(posedge clk); #2;
        init_base  = base;
        init_count = (NN + 1)'(cnt);
        start      = 1'b1;
        @(posedge clk); #2;
        start      = 1'b0;
        init_base  = NN'($urandom_range(0, 15));
        init_count = (NN + 1)'($urandom_range(0, 16));
        if (bpulse) begin
            repeat (2) @(posedge clk);
            #2;
            chk("busy_during_run", 0, busy_w, 2'b11);
            init_base  = NN'(base + 7);
            init_count = 5'd5;
            start      = 1'b1;
            @(posedge clk); #2;
            start      = 1'b0;
        end
        if (stall > 0) begin
            g = 0;
            while (!res_valid_w[0] && g < 3000) begin
                @(posedge clk); #2;
                g++;
            end
            chk("stall_saw_valid", 0, res_valid_w[0], 1);
            repeat (stall) @(posedge clk);
            #2;
            res_ready[0] = 1'b1;
        end
        wait_done(b0, b1);
    endtask

    task automatic set_identity();
        for (int i = 0; i < 16; i++) fn[i] = NN'(i);
    endtask

    task automatic set_increment();
        for (int i = 0; i < 16; i++) fn[i] = NN'(i + 1);
    endtask

    initial begin
        int n, g;
        n_pass = 0; n_tot = 0;
        rst = 1'b1; start = 1'b0; init_base = '0; init_count = '0; res_ready = 2'b11;
        for (int d = 0; d < 2; d++) begin
            s0c[d] = 0; s1c[d] = 0; done_cnt[d] = 0; held[d] = '0;
        end
        set_identity();
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) chk("reset_outputs", d, outs(d), 0);
        @(posedge clk); #2;
        rst = 1'b0;

        do_run(4'd5, 1, 0, 1'b0);
        set_increment();
        do_run(4'd0, 1, 0, 1'b0);
        do_run(4'd15, 2, 5, 1'b0);

        // Abort mid-MEET with an asynchronous reset on the 10th strobe cycle.
        push_expected(4'd0, 1);
        @(posedge clk); #2;
        init_base = 4'd0; init_count = 5'd1; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        n = 0; g = 0;
        while (n < 10 && g < 200) begin
            @(negedge clk);
            g++;
            if (ss0_w[0]) n++;
        end
        chk("reached_10th_meet_cycle", 0, n, 10);
        #1 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) chk("async_reset_outputs", d, outs(d), 0);
        sbq[0].delete();
        sbq[1].delete();
        @(posedge clk); #2;
        rst = 1'b0;

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 16; i++) fn[i] = NN'($urandom_range(0, 15));
            do_run(NN'($urandom_range(0, 15)), $urandom_range(1, 4), 0, r == 0);
        end

        @(posedge clk); #2;
        init_base = 4'd9; init_count = '0; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        @(negedge clk);
        chk("zero_count_done_not_yet", 0, done_w, 2'b00);
        @(negedge clk);
        chk("zero_count_done_pulse", 0, done_w, 2'b11);
        @(negedge clk);
        chk("zero_count_done_clears", 0, done_w, 2'b00);
        chk("zero_count_idle", 0, busy_w, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
